// File: rtl/parallel_to_serial_tx.sv
// parallel_to_serial_tx: pops FIFO words and shifts them out MSB-first with a generated bit clock and frame sync
//
// Ports:
//   clock_i        system clock, all logic on the rising edge
//   reset_ni       synchronous reset, active low
//   enable_i       1 = start or continue popping words
//   fifo_data_i    FIFO head word, valid whenever fifo_empty_i = 0
//   fifo_empty_i   FIFO empty flag
//   fifo_write_i   FIFO write strobe; the FIFO ignores reads in write cycles
//   fifo_read_o    one-cycle pop strobe (combinational, 0 during reset)
//   serial_clock_o bit clock, receiver samples on its rising edge
//   serial_data_o  serial data, MSB first
//   frame_sync_o   high for the whole MSB bit period of each word
//   busy_o         high while shifting a word or inserting gap bits
//   underrun_o     one-cycle pulse: word ended with enable_i = 1 and the FIFO empty
module parallel_to_serial_tx #(
    parameter int WORD_WIDTH = 24,
    parameter int CLK_DIV    = 2,
    parameter int GAP_BITS   = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic [WORD_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic                  fifo_write_i,
    output logic                  fifo_read_o,
    output logic                  serial_clock_o,
    output logic                  serial_data_o,
    output logic                  frame_sync_o,
    output logic                  busy_o,
    output logic                  underrun_o
);
    localparam int DIV_W   = $clog2(2 * CLK_DIV);
    localparam int CNT_MAX = (WORD_WIDTH > GAP_BITS) ? WORD_WIDTH : GAP_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] TOP_BIT  = CNT_W'(WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic                    serial_data_q, frame_sync_q, busy_q, underrun_q;
    logic                    pop_ok, period_end, last_cnt;
    logic                    decide, word_end, pop, underrun_d;

    assign pop_ok     = enable_i & ~fifo_empty_i & ~fifo_write_i;
    assign period_end = div_cnt_q == DIV_LAST;
    assign last_cnt   = bit_cnt_q == '0;

    // bit_cnt_q counts data bits in SHIFT and remaining gap bits in GAP;
    // decide marks the cycles where a new word may be popped.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = period_end ? '0 : div_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        decide     = 1'b0;
        word_end   = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                decide    = 1'b1;
            end
            SHIFT: begin
                if (period_end && !last_cnt) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (period_end && GAP_BITS > 0) begin
                    state_d   = GAP;
                    bit_cnt_d = GAP_LAST;
                end else if (period_end) begin
                    decide   = 1'b1;
                    word_end = 1'b1;
                end
            end
            GAP: begin
                if (period_end && !last_cnt) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (period_end) begin
                    decide   = 1'b1;
                    word_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (decide && pop_ok) begin
            pop       = 1'b1;
            state_d   = SHIFT;
            bit_cnt_d = TOP_BIT;
            div_cnt_d = '0;
            shift_d   = fifo_data_i;
        end else if (decide) begin
            state_d   = IDLE;
            div_cnt_d = '0;
        end
        // A write-blocked pop is a deferral, not an underrun: only a truly empty FIFO flags.
        underrun_d = word_end & ~pop_ok & enable_i & fifo_empty_i;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            serial_data_q <= 1'b0;
            frame_sync_q  <= 1'b0;
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            // Line outputs follow the next state so they move only on bit-period boundaries.
            serial_data_q <= (state_d == SHIFT) & shift_d[WORD_WIDTH-1];
            frame_sync_q  <= (state_d == SHIFT) && (bit_cnt_d == TOP_BIT);
            busy_q        <= state_d != IDLE;
            underrun_q    <= underrun_d;
        end
    end

    assign fifo_read_o    = pop & reset_ni;
    assign serial_clock_o = (state_q == SHIFT) && (div_cnt_q >= DIV_HIGH);
    assign serial_data_o  = serial_data_q;
    assign frame_sync_o   = frame_sync_q;
    assign busy_o         = busy_q;
    assign underrun_o     = underrun_q;
endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// tb_parallel_to_serial_tx: scoreboard bench for two transmitters (GAP_BITS=1 and GAP_BITS=0)
module tb_parallel_to_serial_tx;
    logic        clock = 1'b0;
    logic        rst_n;
    logic        en [2];
    logic        fw [2];
    logic        empty [2];
    logic [23:0] fd [2];
    logic        rd [2];
    logic        sclk [2];
    logic        sd [2];
    logic        fs [2];
    logic        busy [2];
    logic        ur [2];

    logic [23:0] fifo0 [$];
    logic [23:0] fifo1 [$];
    logic [23:0] exp0 [$];
    logic [23:0] exp1 [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    int rd_cnt [2];
    int fs_cnt [2];
    int busy_cnt [2];
    int sclk_cnt [2];
    int ur_cnt [2];
    int frames [2];
    int fs_rise [2];
    int fs_rise_prev [2];
    int ur_cyc [2];
    int bits [2];
    logic [23:0] w [2];
    logic sclk_p [2];
    logic fs_p [2];
    logic rd_s [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        parallel_to_serial_tx #(.WORD_WIDTH(24), .CLK_DIV(2), .GAP_BITS(g == 0 ? 1 : 0)) u_dut (
            .clock_i(clock),
            .reset_ni(rst_n),
            .enable_i(en[g]),
            .fifo_data_i(fd[g]),
            .fifo_empty_i(empty[g]),
            .fifo_write_i(fw[g]),
            .fifo_read_o(rd[g]),
            .serial_clock_o(sclk[g]),
            .serial_data_o(sd[g]),
            .frame_sync_o(fs[g]),
            .busy_o(busy[g]),
            .underrun_o(ur[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic score(input int g, input logic [23:0] got);
        logic [23:0] want;
        check("frame_expected", (g == 0 ? exp0.size() : exp1.size()) != 0, 1);
        if (g == 0 && exp0.size() != 0) begin
            want = exp0.pop_front();
            check("frame_data_g1", got, want);
        end else if (g == 1 && exp1.size() != 0) begin
            want = exp1.pop_front();
            check("frame_data_g0", got, want);
        end
    endtask

    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                bits[g] = 0;
            end else begin
                if (rd[g]) rd_cnt[g]++;
                if (fs[g]) fs_cnt[g]++;
                if (fs[g] && !fs_p[g]) begin
                    fs_rise_prev[g] = fs_rise[g];
                    fs_rise[g] = cyc;
                end
                if (busy[g]) busy_cnt[g]++;
                if (ur[g]) begin
                    ur_cnt[g]++;
                    ur_cyc[g] = cyc;
                end
                if (sclk[g] && !sclk_p[g]) begin
                    sclk_cnt[g]++;
                    if (fs[g]) begin
                        w[g] = {23'd0, sd[g]};
                        bits[g] = 1;
                    end else if (bits[g] > 0) begin
                        w[g] = {w[g][22:0], sd[g]};
                        bits[g]++;
                    end
                    if (bits[g] == 24) begin
                        bits[g] = 0;
                        frames[g]++;
                        score(g, w[g]);
                    end
                end
            end
            sclk_p[g] = sclk[g];
            fs_p[g] = fs[g];
        end
    end

    task automatic refresh();
        empty[0] = fifo0.size() == 0;
        fd[0] = fifo0.size() != 0 ? fifo0[0] : 24'd0;
        empty[1] = fifo1.size() == 0;
        fd[1] = fifo1.size() != 0 ? fifo1[0] : 24'd0;
    endtask

    task automatic push(input int g, input logic [23:0] word);
        if (g == 0) begin
            fifo0.push_back(word);
            exp0.push_back(word);
        end else begin
            fifo1.push_back(word);
            exp1.push_back(word);
        end
        refresh();
    endtask

    task automatic step();
        #1;
        rd_s[0] = rd[0];
        rd_s[1] = rd[1];
        @(posedge clock);
        #1;
        if (rd_s[0]) void'(fifo0.pop_front());
        if (rd_s[1]) void'(fifo1.pop_front());
        refresh();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s_rd, s_fs, s_busy, s_sclk, s_fr, s_ur;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            en[g] = 1'b0;
            fw[g] = 1'b0;
        end
        refresh();
        push(0, 24'hA5C3F0);
        en[0] = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_quiet", {rd[0], sclk[0], sd[0], fs[0], busy[0], ur[0]}, 0);
        end

        s_rd = rd_cnt[0]; s_fs = fs_cnt[0]; s_busy = busy_cnt[0];
        s_sclk = sclk_cnt[0]; s_fr = frames[0]; s_ur = ur_cnt[0];
        rst_n = 1'b1;
        repeat (130) step();
        check("g1_read_pulses", rd_cnt[0] - s_rd, 1);
        check("g1_fsync_clocks", fs_cnt[0] - s_fs, 4);
        check("g1_sclk_rises", sclk_cnt[0] - s_sclk, 24);
        check("g1_busy_clocks", busy_cnt[0] - s_busy, 100);
        check("g1_frames", frames[0] - s_fr, 1);
        check("g1_underrun", ur_cnt[0] - s_ur, 1);
        check("g1_idle_busy", busy[0], 0);
        en[0] = 1'b0;

        s_rd = rd_cnt[1]; s_sclk = sclk_cnt[1]; s_fr = frames[1]; s_ur = ur_cnt[1];
        push(1, 24'h000001);
        push(1, 24'hFFFFFF);
        en[1] = 1'b1;
        repeat (250) step();
        check("g0_frame_spacing", fs_rise[1] - fs_rise_prev[1], 96);
        check("g0_frames", frames[1] - s_fr, 2);
        check("g0_read_pulses", rd_cnt[1] - s_rd, 2);
        check("g0_sclk_rises", sclk_cnt[1] - s_sclk, 48);
        check("g0_underrun", ur_cnt[1] - s_ur, 1);

        s_ur = ur_cnt[1];
        push(1, 24'h3C3C3C);
        repeat (150) step();
        check("underrun_once", ur_cnt[1] - s_ur, 1);
        check("underrun_timing", ur_cyc[1] - fs_rise[1], 96);
        check("underrun_idle", busy[1], 0);
        en[1] = 1'b0;

        s_fr = frames[0];
        en[0] = 1'b1;
        fw[0] = 1'b1;
        push(0, 24'h5A5A5A);
        #1;
        check("write_defer_1", rd[0], 0);
        step();
        #1;
        check("write_defer_2", rd[0], 0);
        step();
        fw[0] = 1'b0;
        #1;
        check("pop_after_write", rd[0], 1);
        repeat (120) step();
        check("deferred_frame", frames[0] - s_fr, 1);

        push(0, 24'h123456);
        for (int i = 0; i < 50 && !fs[0]; i++) step();
        check("mid_reset_start", fs[0], 1);
        repeat (40) step();
        rst_n = 1'b0;
        step();
        check("mid_reset_outputs", {rd[0], sclk[0], sd[0], fs[0], busy[0], ur[0]}, 0);
        if (exp0.size() != 0) void'(exp0.pop_front());
        push(0, 24'h654321);
        #1;
        check("reset_blocks_read", rd[0], 0);
        step();
        s_fr = frames[0];
        rst_n = 1'b1;
        repeat (120) step();
        check("clean_frame_after_reset", frames[0] - s_fr, 1);
        check("scoreboard_g1_empty", exp0.size(), 0);
        check("scoreboard_g0_empty", exp1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
